satd_block_feeder: RTL

Pixel-stream-to-row front end for the SATD datapath. Accepts one ORG/CUR pixel pair per handshake and assembles a full 8x8 block. Then presents the block to the SATD core as eight 64-bit ORG/CUR rows over a valid/ready interface. It replaces bench-driven row stimulus with a producer that streams real block data into the core's `ORG`/`CUR` inputs.

---
 rtl/satd_block_feeder_if.sv | 32 +++
 rtl/satd_block_feeder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/satd_block_feeder_if.sv
// Pixel-in / row-out bus of satd_block_feeder. The feeder drives the row side through
// modport master; the pixel producer and SATD core attach through modport slave.
interface satd_block_feeder_if #(
    parameter int PIX_W   = 8,
    parameter int ROW_PIX = 8,
    parameter int ROWS    = 8
);
    localparam int ROW_W  = ROW_PIX * PIX_W;
    localparam int RIDX_W = $clog2(ROWS);

    logic              in_valid;
    logic              in_ready;
    logic [PIX_W-1:0]  in_org;
    logic [PIX_W-1:0]  in_cur;
    logic              out_valid;
    logic              out_ready;
    logic [ROW_W-1:0]  ORG;
    logic [ROW_W-1:0]  CUR;
    logic [RIDX_W-1:0] out_row;
    logic              out_last;
    logic              blk_done;

    modport master (
        input  in_valid, in_org, in_cur, out_ready,
        output in_ready, out_valid, ORG, CUR, out_row, out_last, blk_done
    );

    modport slave (
        output in_valid, in_org, in_cur, out_ready,
        input  in_ready, out_valid, ORG, CUR, out_row, out_last, blk_done
    );
endinterface

// File: rtl/satd_block_feeder.sv
// Packs 64 raster-order ORG/CUR pixel pairs into an 8x8 block and streams it as 8 rows.
// Define SATD_FEEDER_PINGPONG_EN for two alternating block buffers (fill one, stream the other).
module satd_block_feeder #(
    parameter int PIX_W   = 8,
    parameter int ROW_PIX = 8,
    parameter int ROWS    = 8
) (
    input  logic                clk,
    input  logic                rst,
    satd_block_feeder_if.master bus
);
    localparam int COL_W  = $clog2(ROW_PIX);
    localparam int RIDX_W = $clog2(ROWS);
    localparam int CNT_W  = COL_W + RIDX_W;
    localparam int ROW_W  = ROW_PIX * PIX_W;
`ifdef SATD_FEEDER_PINGPONG_EN
    localparam logic SEL_STEP = 1'b1;
`else
    // Selectors never move, so buffer 1 is never written or read and trims away.
    localparam logic SEL_STEP = 1'b0;
`endif
    localparam logic [CNT_W-1:0]  LAST_PIX = CNT_W'(ROWS * ROW_PIX - 1);
    localparam logic [RIDX_W-1:0] LAST_ROW = RIDX_W'(ROWS - 1);

    typedef enum logic {BUF_FILL = 1'b0, BUF_FULL = 1'b1} buf_state_t;
    typedef logic [ROWS-1:0][ROW_PIX-1:0][PIX_W-1:0] block_t;

    buf_state_t        buf_state_r [2];
    buf_state_t        buf_state_s [2];
    block_t            org_buf_r [2];
    block_t            cur_buf_r [2];
    logic              fill_sel_r;
    logic              fill_sel_s;
    logic              stream_sel_r;
    logic              stream_sel_s;
    logic [CNT_W-1:0]  pix_cnt_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              out_last_r;
    logic              blk_done_r;
    logic [RIDX_W-1:0] out_row_r;
    logic [ROW_W-1:0]  org_row_r;
    logic [ROW_W-1:0]  cur_row_r;
    logic              accept_s;
    logic              last_pix_s;
    logic              out_fire_s;
    logic              row_last_fire_s;
    logic              out_valid_s;
    logic              load_s;
    logic [RIDX_W-1:0] load_row_s;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.ORG       = org_row_r;
    assign bus.CUR       = cur_row_r;
    assign bus.out_row   = out_row_r;
    assign bus.out_last  = out_last_r;
    assign bus.blk_done  = blk_done_r;

    // Handshakes, buffer next-state and which row (if any) to present next
    always_comb begin
        accept_s        = bus.in_valid && in_ready_r;
        last_pix_s      = accept_s && (pix_cnt_r == LAST_PIX);
        out_fire_s      = out_valid_r && bus.out_ready;
        row_last_fire_s = out_fire_s && (out_row_r == LAST_ROW);
        buf_state_s[0]  = buf_state_r[0];
        buf_state_s[1]  = buf_state_r[1];
        if (last_pix_s) begin
            buf_state_s[fill_sel_r] = BUF_FULL;
            fill_sel_s              = fill_sel_r ^ SEL_STEP;
        end else begin
            fill_sel_s = fill_sel_r;
        end
        if (row_last_fire_s) begin
            buf_state_s[stream_sel_r] = BUF_FILL;
            stream_sel_s              = stream_sel_r ^ SEL_STEP;
        end else begin
            stream_sel_s = stream_sel_r;
        end
        out_valid_s = (buf_state_s[stream_sel_s] == BUF_FULL);
        // Row 0 of a full buffer is always complete, even on the edge its 64th pixel lands.
        if (out_fire_s && !row_last_fire_s) begin
            load_s     = 1'b1;
            load_row_s = out_row_r + RIDX_W'(1);
        end else if (out_valid_s && (!out_valid_r || row_last_fire_s)) begin
            load_s     = 1'b1;
            load_row_s = RIDX_W'(0);
        end else begin
            load_s     = 1'b0;
            load_row_s = out_row_r;
        end
    end

    // Buffer full/free state and fill/stream selectors
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_state_r[0] <= BUF_FILL;
            buf_state_r[1] <= BUF_FILL;
            fill_sel_r     <= 1'b0;
            stream_sel_r   <= 1'b0;
        end else begin
            buf_state_r  <= buf_state_s;
            fill_sel_r   <= fill_sel_s;
            stream_sel_r <= stream_sel_s;
        end
    end

    // Pixel counter and registered handshake/row outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt_r   <= CNT_W'(0);
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            blk_done_r  <= 1'b0;
            out_row_r   <= RIDX_W'(0);
            out_last_r  <= 1'b0;
            org_row_r   <= ROW_W'(0);
            cur_row_r   <= ROW_W'(0);
        end else begin
            in_ready_r  <= (buf_state_s[fill_sel_s] == BUF_FILL);
            out_valid_r <= out_valid_s;
            blk_done_r  <= row_last_fire_s;
            if (accept_s) begin
                pix_cnt_r <= pix_cnt_r + CNT_W'(1);
            end
            if (load_s) begin
                org_row_r  <= org_buf_r[stream_sel_s][load_row_s];
                cur_row_r  <= cur_buf_r[stream_sel_s][load_row_s];
                out_row_r  <= load_row_s;
                out_last_r <= (load_row_s == LAST_ROW);
            end else if (!out_valid_s) begin
                out_row_r  <= RIDX_W'(0);
                out_last_r <= 1'b0;
            end
        end
    end

    // Pixel capture into the buffer being filled; pixel k of a row lands in byte k
    always_ff @(posedge clk) begin
        if (accept_s) begin
            org_buf_r[fill_sel_r][pix_cnt_r[CNT_W-1:COL_W]][pix_cnt_r[COL_W-1:0]] <= bus.in_org;
            cur_buf_r[fill_sel_r][pix_cnt_r[CNT_W-1:COL_W]][pix_cnt_r[COL_W-1:0]] <= bus.in_cur;
        end
    end
endmodule
